miner_header_loader: RTL and testbench



---
 rtl/miner_pkg.sv | 22 ++
 rtl/miner_header_loader.sv | 116 +++++++++++
 tb/tb_miner_header_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types, constants and helpers for the miner header loader
package miner_pkg;

    localparam int WORD_W               = 32;
    localparam int DEFAULT_HEADER_WORDS = 20;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } loader_state_t;

    // The stream arrives little-endian; the hashing core expects big-endian words.
    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/miner_header_loader.sv
// rtl/miner_header_loader.sv - assembles MM2S stream frames into block headers, dropping malformed frames
module miner_header_loader
    import miner_pkg::*;
#(
    parameter int HEADER_WORDS = DEFAULT_HEADER_WORDS,
    parameter bit BYTE_SWAP    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WORD_W-1:0]              s_tdata,
    input  logic [3:0]                     s_tkeep,
    input  logic                           s_tlast,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    output logic [WORD_W*HEADER_WORDS-1:0] hdr_data,
    output logic                           hdr_valid,
    input  logic                           hdr_ready,
    output logic [15:0]                    frame_count,
    output logic [15:0]                    err_count
);

    localparam int IDX_W = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEADER_WORDS - 1);

    loader_state_t                              state_q, state_d;
    logic [IDX_W-1:0]                           idx_q, idx_d;
    logic [HEADER_WORDS-1:0][WORD_W-1:0]        hdr_q, hdr_d;
    logic [15:0]                                frame_q, frame_d;
    logic [15:0]                                err_q, err_d;
    // Holds s_tready low for the whole time reset is asserted without a path from rst.
    logic                                       active_q, active_d;

    logic              accept;
    logic [WORD_W-1:0] word_in;

    assign s_tready    = active_q && (state_q != HOLD);
    assign hdr_valid   = (state_q == HOLD);
    assign hdr_data    = hdr_q;
    assign frame_count = frame_q;
    assign err_count   = err_q;

    assign accept  = s_tvalid && s_tready;
    assign word_in = BYTE_SWAP ? byte_swap32(s_tdata) : s_tdata;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hdr_d    = hdr_q;
        frame_d  = frame_q;
        err_d    = err_q;
        active_d = 1'b1;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (s_tkeep != 4'hF) begin
                        err_d   = sat_inc16(err_q);
                        idx_d   = '0;
                        state_d = s_tlast ? FILL : DRAIN;
                    end else if (idx_q == LAST_IDX) begin
                        if (s_tlast) begin
                            hdr_d[idx_q] = word_in;
                            state_d      = HOLD;
                        end else begin
                            err_d   = sat_inc16(err_q);
                            idx_d   = '0;
                            state_d = DRAIN;
                        end
                    end else if (s_tlast) begin
                        err_d = sat_inc16(err_q);
                        idx_d = '0;
                    end else begin
                        hdr_d[idx_q] = word_in;
                        idx_d        = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_tlast) begin
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (hdr_ready) begin
                    frame_d = sat_inc16(frame_q);
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            idx_q    <= '0;
            hdr_q    <= '0;
            frame_q  <= '0;
            err_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hdr_q    <= hdr_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

endmodule

// File: tb/tb_miner_header_loader.sv
// tb/tb_miner_header_loader.sv - directed and random-gap checks of miner_header_loader
module tb_miner_header_loader;

    localparam int HW = 20;
    localparam int HB = 32 * HW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   s_tdata = '0;
    logic [3:0]    s_tkeep = 4'hF;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [HB-1:0] hdr_data;
    logic          hdr_valid;
    logic          hdr_ready = 1'b1;
    logic [15:0]   frame_count;
    logic [15:0]   err_count;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_hdr = 0;
    logic [HB-1:0] exp_q[$];
    logic [HB-1:0] held;
    int            max_gap = 0;

    miner_header_loader #(.HEADER_WORDS(HW), .BYTE_SWAP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .hdr_data   (hdr_data),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .frame_count(frame_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [HB-1:0] got, input logic [HB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HB-1:0] exp_hdr(input logic [31:0] base);
        logic [HB-1:0] r;
        logic [31:0]   w;
        r = '0;
        for (int k = 0; k < HW; k++) begin
            w = base + 32'(k);
            r[32*k +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] keep, input logic last);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        s_tdata  = d;
        s_tkeep  = keep;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            step();
            n++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!acc) check("beat_timeout", acc, 1);
    endtask

    task automatic send_frame(input logic [31:0] base, input int nbeats, input int bad_beat,
                              input bit expect_good);
        if (expect_good) exp_q.push_back(exp_hdr(base));
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < max_gap; g++) begin
                if ($urandom_range(0, 1) == 1) step();
            end
            send_beat(base + 32'(k), (k == bad_beat) ? 4'h7 : 4'hF, k == nbeats - 1);
        end
        if (expect_good) check("hdr_valid_latency", hdr_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_hdr_valid", hdr_valid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_hdr_data", hdr_data, 0);
        rst = 1'b0;
        step();
        check("post_rst_s_tready", s_tready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && hdr_valid && hdr_ready) begin
            if (exp_q.size() == 0) begin
                check("hdr_unexpected", hdr_valid, 0);
            end else begin
                check("hdr_data", hdr_data, exp_q.pop_front());
                n_hdr++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        step();
        do_reset();

        // good frame: latency, first word swapped, counter
        send_frame(32'h00010203, HW, -1, 1);
        check("word0_swapped", hdr_data[31:0], 32'h03020100);
        step();
        check("frame_count_1", frame_count, 1);
        check("after_hs_valid", hdr_valid, 0);
        check("after_hs_ready", s_tready, 1);

        // short frame then good frame
        send_frame(32'hAA000000, 6, -1, 0);
        step();
        check("short_err", err_count, 1);
        check("short_no_valid", hdr_valid, 0);
        send_frame(32'h11223344, HW, -1, 1);
        step();
        check("short_then_good_frames", frame_count, 2);

        // long frame then good frame
        send_frame(32'hBB000000, 25, -1, 0);
        step();
        check("long_err", err_count, 2);
        check("long_no_valid", hdr_valid, 0);
        send_frame(32'h55667788, HW, -1, 1);
        step();
        check("long_then_good_frames", frame_count, 3);

        // backpressure: header held while a second frame waits
        hdr_ready = 1'b0;
        send_frame(32'hC0C1C2C3, HW, -1, 1);
        held = hdr_data;
        check("bp_held_value", held, exp_hdr(32'hC0C1C2C3));
        s_tdata  = 32'hD0000000;
        s_tkeep  = 4'hF;
        s_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_s_tready", s_tready, 0);
            check("bp_hdr_valid", hdr_valid, 1);
            check("bp_hdr_stable", hdr_data, held);
            step();
        end
        hdr_ready = 1'b1;
        send_frame(32'hD0000000, HW, -1, 1);
        step();
        check("bp_frames", frame_count, 5);

        // bad tkeep on beat 3: rest of frame drained
        send_frame(32'hE0000000, HW, 3, 0);
        step();
        check("tkeep_err", err_count, 3);
        check("tkeep_no_valid", hdr_valid, 0);
        send_frame(32'h0F0E0D0C, HW, -1, 1);
        step();
        check("tkeep_then_good_frames", frame_count, 6);

        // reset in the middle of a frame
        for (int k = 0; k < 10; k++) send_beat(32'h99000000 + 32'(k), 4'hF, 1'b0);
        do_reset();
        send_frame(32'h12345678, HW, -1, 1);
        step();
        check("post_rst_frames", frame_count, 1);
        check("post_rst_err", err_count, 0);

        // random valid gaps over 100 frames
        do_reset();
        n_hdr   = 0;
        max_gap = 3;
        for (int f = 0; f < 100; f++) send_frame($urandom, HW, -1, 1);
        step();
        step();
        check("rand_frame_count", frame_count, 100);
        check("rand_err_count", err_count, 0);
        check("rand_hdr_seen", n_hdr, 100);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
